// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg: shared UART types, parity codes and sizing helpers | rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int calc_div(input int freq, input int baud);
    return freq / baud;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick: enable-gated divider, tick on the last clock of each period | rev 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int                 c_cnt_w = cnt_width(DIV);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  // Held at zero while disabled so each frame starts a fresh bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == c_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// uart_tx_ctrl: valid/ready byte framer driving a registered UART tx line | rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000,
  parameter int BAUD      = 90,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              bit_tick
);

  localparam int                 c_div       = calc_div(CLK_FREQ, BAUD);
  localparam int                 c_idx_w     = cnt_width(DATA_W);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(DATA_W - 1);
  localparam logic               c_last_stop = (STOP_BITS == 2);

  if (c_div < 2) begin : g_chk_div
    $error("uart_tx_ctrl: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end
  if (PARITY > PAR_ODD || PARITY < PAR_NONE) begin : g_chk_par
    $error("uart_tx_ctrl: PARITY must be 0, 1 or 2");
  end

  state_e              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   shift_d;
  logic [c_idx_w-1:0]  idx_q;
  logic                stop_q;
  logic                par_q;
  logic                par_d;
  logic                tx_q;
  logic                ready_q;
  logic                busy_q;
  logic                tick;

  uart_baud_tick #(
    .DIV (c_div)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy_q),
    .tick  (tick)
  );

  assign shift_d = shift_q >> 1;
  // Parity is fixed at acceptance so later tx_data changes cannot leak in.
  assign par_d   = (^tx_data) ^ (PARITY == PAR_ODD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_valid && ready_q) begin
            shift_q <= tx_data;
            par_q   <= par_d;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (idx_q == c_last_idx) begin
              if (PARITY != PAR_NONE) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                stop_q  <= 1'b0;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              shift_q <= shift_d;
              tx_q    <= shift_d[0];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q <= ST_STOP;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_q == c_last_stop) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign bit_tick = tick;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// tb_uart_tx_ctrl: directed checks of framing, timing, parity, stop bits, reset | rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data  [4];
  logic       valid [4];
  logic       txs   [4];
  logic       rdy   [4];
  logic       bsy   [4];
  logic       tck   [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2 -- all DIV = 11.
  uart_tx_ctrl #(.PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .bit_tick(tck[0]));
  uart_tx_ctrl #(.PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .bit_tick(tck[1]));
  uart_tx_ctrl #(.PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]), .bit_tick(tck[2]));
  uart_tx_ctrl #(.PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]), .bit_tick(tck[3]));

  // Raise valid and wait for the acceptance edge; returns at edge+1 with w = edges waited.
  task automatic start_frame(input int k, input logic [7:0] d, output int w);
    bit prior;
    bit acc;
    acc = 1'b0;
    w = 0;
    data[k]  = d;
    valid[k] = 1'b1;
    while (!acc && w < 20) begin
      prior = rdy[k];
      @(posedge clk); #1;
      w++;
      if (prior) acc = 1'b1;
    end
    valid[k] = 1'b0;
    total++;
    if (!acc) begin bad++; $display("FAIL accept_timeout inst=%0d got=none want=accept", k); end
  endtask

  // Sample every clock from acceptance until tx_ready returns; counts per-clock tx mismatches.
  task automatic run_frame(input int k, input logic [15:0] exp, input int nbits, input bit noise,
                           output int len, output int ticks, output int badc);
    int c;
    int s;
    logic e;
    c = 0; ticks = 0; badc = 0;
    while (rdy[k] !== 1'b1 && c < 400) begin
      s = c / 11;
      e = 1'b1;
      if (s < nbits) e = exp[s[3:0]];
      if (txs[k] !== e) badc++;
      if (tck[k] === 1'b1) ticks++;
      if (noise) begin valid[k] = c[0]; data[k] = 8'(c * 37); end
      @(posedge clk); #1;
      c++;
    end
    valid[k] = 1'b0;
    data[k]  = 8'h00;
    len = c;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++; if (txs[0] !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b want=1", txs[0]); end
    total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", rdy[0]); end
    total++; if (bsy[0] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bsy[0]); end
    total++; if (tck[0] !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b want=0", tck[0]); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL rst_hold_ready got=%b want=0", rdy[0]); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (rdy[k] !== 1'b1) begin bad++; $display("FAIL rel_ready inst=%0d got=%b want=1", k, rdy[k]); end
    end
    total++; if (txs[0] !== 1'b1) begin bad++; $display("FAIL rel_tx got=%b want=1", txs[0]); end
  endtask

  task automatic test_basic_8n1();
    int w, len, ticks, badc;
    start_frame(0, 8'hA5, w);
    total++; if (w !== 1) begin bad++; $display("FAIL basic_accept_wait got=%0d want=1", w); end
    run_frame(0, 16'b1_10100101_0, 10, 1'b0, len, ticks, badc);
    total++; if (badc !== 0) begin bad++; $display("FAIL basic_tx_cycles got=%0d want=0", badc); end
    total++; if (len !== 110) begin bad++; $display("FAIL basic_len got=%0d want=110", len); end
    total++; if (ticks !== 10) begin bad++; $display("FAIL basic_ticks got=%0d want=10", ticks); end
  endtask

  task automatic test_back_to_back();
    int w, badc, second;
    int s;
    logic e, prev, r110, r111, r221;
    logic [9:0] f1, f2;
    f1 = 10'b1_00000000_0;
    f2 = 10'b1_11111111_0;
    badc = 0; second = -1; r110 = 1'b0; r111 = 1'b1; r221 = 1'b0;
    start_frame(0, 8'h00, w);
    valid[0] = 1'b1;
    data[0]  = 8'hFF;
    prev = 1'b0;
    for (int c = 0; c <= 225; c++) begin
      if (c < 110) begin
        s = c / 11; e = f1[s[3:0]];
      end else if (c < 111) begin
        e = 1'b1;
      end else if (c < 221) begin
        s = (c - 111) / 11; e = f2[s[3:0]];
      end else begin
        e = 1'b1;
      end
      if (txs[0] !== e) badc++;
      if (c > 0 && second < 0 && prev === 1'b1 && txs[0] === 1'b0) second = c;
      if (c == 110) r110 = rdy[0];
      if (c == 111) r111 = rdy[0];
      if (c == 221) r221 = rdy[0];
      if (c == 150) valid[0] = 1'b0;
      prev = txs[0];
      @(posedge clk); #1;
    end
    total++; if (badc !== 0) begin bad++; $display("FAIL b2b_tx_cycles got=%0d want=0", badc); end
    total++; if (second !== 111) begin bad++; $display("FAIL b2b_spacing got=%0d want=111", second); end
    total++; if (r110 !== 1'b1) begin bad++; $display("FAIL b2b_gap_ready got=%b want=1", r110); end
    total++; if (r111 !== 1'b0) begin bad++; $display("FAIL b2b_second_ready got=%b want=0", r111); end
    total++; if (r221 !== 1'b1) begin bad++; $display("FAIL b2b_end_ready got=%b want=1", r221); end
  endtask

  task automatic test_parity();
    int w, len, ticks, badc;
    start_frame(1, 8'hA5, w);
    run_frame(1, 16'b1_0_10100101_0, 11, 1'b0, len, ticks, badc);
    total++; if (badc !== 0) begin bad++; $display("FAIL even_tx_cycles got=%0d want=0", badc); end
    total++; if (len !== 121) begin bad++; $display("FAIL even_len got=%0d want=121", len); end
    start_frame(2, 8'hA5, w);
    run_frame(2, 16'b1_1_10100101_0, 11, 1'b0, len, ticks, badc);
    total++; if (badc !== 0) begin bad++; $display("FAIL odd_tx_cycles got=%0d want=0", badc); end
    total++; if (len !== 121) begin bad++; $display("FAIL odd_len got=%0d want=121", len); end
  endtask

  task automatic test_two_stop();
    int w, len, ticks, badc;
    start_frame(3, 8'h3C, w);
    run_frame(3, 16'b11_00111100_0, 11, 1'b0, len, ticks, badc);
    total++; if (badc !== 0) begin bad++; $display("FAIL stop2_tx_cycles got=%0d want=0", badc); end
    total++; if (len !== 121) begin bad++; $display("FAIL stop2_len got=%0d want=121", len); end
    total++; if (ticks !== 11) begin bad++; $display("FAIL stop2_ticks got=%0d want=11", ticks); end
  endtask

  task automatic test_reset_midframe();
    int w, len, ticks, badc;
    start_frame(0, 8'h5A, w);
    repeat (40) @(posedge clk);
    #1;
    total++; if (txs[0] !== 1'b0) begin bad++; $display("FAIL mid_tx_before got=%b want=0", txs[0]); end
    total++; if (bsy[0] !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", bsy[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (txs[0] !== 1'b1) begin bad++; $display("FAIL mid_rst_tx got=%b want=1", txs[0]); end
    total++; if (bsy[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", bsy[0]); end
    total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", rdy[0]); end
    data[0]  = 8'hC3;
    valid[0] = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b want=1", rdy[0]); end
    total++; if (bsy[0] !== 1'b0) begin bad++; $display("FAIL mid_rel_busy got=%b want=0", bsy[0]); end
    start_frame(0, 8'hC3, w);
    total++; if (w !== 1) begin bad++; $display("FAIL mid_accept_wait got=%0d want=1", w); end
    run_frame(0, 16'b1_11000011_0, 10, 1'b0, len, ticks, badc);
    total++; if (badc !== 0) begin bad++; $display("FAIL mid_next_tx_cycles got=%0d want=0", badc); end
    total++; if (len !== 110) begin bad++; $display("FAIL mid_next_len got=%0d want=110", len); end
  endtask

  task automatic test_busy_ignore();
    int w, len, ticks, badc;
    start_frame(0, 8'h96, w);
    run_frame(0, 16'b1_10010110_0, 10, 1'b1, len, ticks, badc);
    total++; if (badc !== 0) begin bad++; $display("FAIL noise_tx_cycles got=%0d want=0", badc); end
    total++; if (len !== 110) begin bad++; $display("FAIL noise_len got=%0d want=110", len); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bsy[0] !== 1'b0) begin bad++; $display("FAIL noise_extra_busy got=%b want=0", bsy[0]); end
    total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL noise_extra_ready got=%b want=1", rdy[0]); end
    data[0]  = 8'h0F;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    total++; if (bsy[0] !== 1'b1) begin bad++; $display("FAIL pulse_busy got=%b want=1", bsy[0]); end
    total++; if (txs[0] !== 1'b0) begin bad++; $display("FAIL pulse_tx got=%b want=0", txs[0]); end
    run_frame(0, 16'b1_00001111_0, 10, 1'b0, len, ticks, badc);
    total++; if (badc !== 0) begin bad++; $display("FAIL pulse_tx_cycles got=%0d want=0", badc); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      data[k]  = 8'h00;
      valid[k] = 1'b0;
    end
    test_reset();
    test_basic_8n1();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_reset_midframe();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
